// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle logic/arith, iterative shift-add multiply and restoring divide,
// with result write-back into a register file. Define ALU_REMAINDER_EN to expose the divide remainder.
module alu_exec_unit #(
    parameter int WIDTH  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [REG_AW-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              carry_out,
    output logic              zero,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
`ifdef ALU_REMAINDER_EN
    ,
    output logic [WIDTH-1:0]  remainder
`endif
);

    localparam int NREGS = 1 << REG_AW;
    localparam int CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Handshake: an op is taken on a rising edge where in_valid && in_ready; a result is
    // released on a rising edge where out_valid && out_ready. Each side holds its payload until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    prem_q, prem_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic [WIDTH-1:0]    regs_q [NREGS];
`ifdef ALU_REMAINDER_EN
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    fin_rem;
`endif

    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      diff;
    logic [2*WIDTH-1:0]  prod_next;
    logic [WIDTH:0]      div_trial;
    logic [WIDTH-1:0]    div_sub;
    logic                div_fit;
    logic [WIDTH-1:0]    prem_next;
    logic [WIDTH-1:0]    quo_next;
    logic                fin_en;
    logic [WIDTH-1:0]    fin_result;
    logic                fin_carry;
    logic [REG_AW-1:0]   wb_addr;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        prod_next = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
        // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
        div_trial = {prem_q, quo_q[WIDTH-1]};
        div_sub   = div_trial[WIDTH-1:0] - b_q;
        div_fit   = (div_trial >= {1'b0, b_q});
        prem_next = div_fit ? div_sub : div_trial[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], div_fit};
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        quo_d      = quo_q;
        prem_d     = prem_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        fin_en     = 1'b0;
        fin_result = '0;
        fin_carry  = 1'b0;
        wb_addr    = rd_q;
`ifdef ALU_REMAINDER_EN
        rem_d      = rem_q;
        fin_rem    = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = opcode;
                    a_d     = a;
                    b_d     = b;
                    rd_d    = rd;
                    wb_addr = rd;
                    cnt_d   = '0;
                    prod_d  = '0;
                    prem_d  = '0;
                    quo_d   = a;
                    case (opcode)
                        OP_ADD: begin fin_en = 1'b1; fin_result = sum[WIDTH-1:0];  fin_carry = sum[WIDTH]; end
                        OP_SUB: begin fin_en = 1'b1; fin_result = diff[WIDTH-1:0]; fin_carry = diff[WIDTH]; end
                        OP_AND: begin fin_en = 1'b1; fin_result = a & b; end
                        OP_OR:  begin fin_en = 1'b1; fin_result = a | b; end
                        OP_XOR: begin fin_en = 1'b1; fin_result = a ^ b; end
                        OP_CMP: begin
                            fin_en        = 1'b1;
                            fin_result[0] = (a == b);
                            fin_result[1] = (a < b);
                        end
                        OP_MUL: state_d = S_EXEC;
                        default: begin
                            if (b == '0) begin
                                fin_en    = 1'b1;
                                fin_carry = 1'b1;
`ifdef ALU_REMAINDER_EN
                                fin_rem   = a;
`endif
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                    endcase
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (op_q == OP_MUL) begin
                    prod_d = prod_next;
                end else begin
                    prem_d = prem_next;
                    quo_d  = quo_next;
                end
                if (cnt_q == CNT_LAST) begin
                    fin_en = 1'b1;
                    if (op_q == OP_MUL) begin
                        fin_result = prod_next[WIDTH-1:0];
                        fin_carry  = |prod_next[2*WIDTH-1:WIDTH];
                    end else begin
                        fin_result = quo_next;
`ifdef ALU_REMAINDER_EN
                        fin_rem    = prem_next;
`endif
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin_en) begin
            state_d  = S_DONE;
            result_d = fin_result;
            carry_d  = fin_carry;
            zero_d   = (fin_result == '0);
`ifdef ALU_REMAINDER_EN
            rem_d    = fin_rem;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            prem_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_REMAINDER_EN
            rem_q    <= '0;
`endif
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            quo_q    <= quo_d;
            prem_q   <= prem_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
`ifdef ALU_REMAINDER_EN
            rem_q    <= rem_d;
`endif
            if (fin_en) regs_q[wb_addr] <= fin_result;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_EXEC);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign dbg_data  = regs_q[dbg_sel];
`ifdef ALU_REMAINDER_EN
    assign remainder = rem_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: 8-bit and 16-bit instances checked against an arithmetic reference model.
module tb_alu_exec_unit;

    typedef struct packed {
        logic        c;
        logic [15:0] r;
        logic [15:0] m;
        logic [7:0]  lat;
    } res_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       in_valid, in_ready, out_valid, out_ready, carry_out, zero, busy;
    logic [2:0] opcode, rd, dbg_sel;
    logic [7:0] a, b, result, dbg_data;
`ifdef ALU_REMAINDER_EN
    logic [7:0] remainder;
`endif

    // 16-bit instance
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_carry, w_zero, w_busy;
    logic [2:0]  w_opcode;
    logic [3:0]  w_rd, w_dbg_sel;
    logic [15:0] w_a, w_b, w_result, w_dbg_data;
`ifdef ALU_REMAINDER_EN
    logic [15:0] w_rem;
`endif

    alu_exec_unit #(.WIDTH(8), .REG_AW(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .a(a), .b(b), .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .zero(zero), .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef ALU_REMAINDER_EN
        , .remainder(remainder)
`endif
    );

    alu_exec_unit #(.WIDTH(16), .REG_AW(4)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .opcode(w_opcode),
        .a(w_a), .b(w_b), .rd(w_rd), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .carry_out(w_carry), .zero(w_zero), .busy(w_busy),
        .dbg_sel(w_dbg_sel), .dbg_data(w_dbg_data)
`ifdef ALU_REMAINDER_EN
        , .remainder(w_rem)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [40:0] exp_q[$];
    logic [7:0]  mregs [8];
    logic [15:0] mregs_w [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the operation rules, using wide integer arithmetic.
    function automatic res_t model(input int w, input logic [2:0] op, input logic [15:0] av,
                                   input logic [15:0] bv);
        longint unsigned x, y, p, mask;
        res_t e;
        x    = 64'(av);
        y    = 64'(bv);
        mask = (64'd1 << w) - 64'd1;
        e    = '0;
        e.lat = 8'd1;
        case (op)
            3'd0: begin p = x + y; e.r = 16'(p & mask); e.c = (p > mask); end
            3'd1: begin e.r = 16'((x - y) & mask); e.c = (x < y); end
            3'd2: e.r = 16'(x & y);
            3'd3: e.r = 16'(x | y);
            3'd4: e.r = 16'(x ^ y);
            3'd5: begin p = x * y; e.r = 16'(p & mask); e.c = (p > mask); e.lat = 8'(w + 1); end
            3'd6: begin
                if (y == 0) begin
                    e.c = 1'b1;
                    e.m = 16'(x);
                end else begin
                    e.r   = 16'(x / y);
                    e.m   = 16'(x % y);
                    e.lat = 8'(w + 1);
                end
            end
            default: e.r = 16'((x == y ? 1 : 0) + (x < y ? 2 : 0));
        endcase
        return e;
    endfunction

    // ---------------- driver tasks (8-bit) ----------------
    task automatic send(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] rdv);
        res_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        opcode   = op;
        a        = av;
        b        = bv;
        rd       = rdv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(8, op, 16'(av), 16'(bv));
        exp_q.push_back(e);
        mregs[rdv] = e.r[7:0];
    endtask

    // Waits for out_valid while throwing junk requests and operand changes at the busy unit.
    task automatic wait_out(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) begin
                nbusy++;
                in_valid = 1'($urandom_range(0, 1));
                opcode   = 3'($urandom_range(0, 7));
                a        = 8'($urandom_range(0, 255));
                b        = 8'($urandom_range(0, 255));
                rd       = 3'($urandom_range(0, 7));
            end
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
    endtask

    task automatic consume(input string tag, input logic [2:0] rdv, input int lat,
                           input int nbusy, input int hold);
        res_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s_exp_q: observed empty expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"},   32'(lat),       32'(e.lat));
        check({tag, "_busy"},  32'(nbusy),     32'(e.lat) - 32'd1);
        check({tag, "_res"},   32'(result),    32'(e.r));
        check({tag, "_carry"}, 32'(carry_out), 32'(e.c));
        check({tag, "_zero"},  32'(zero),      32'(e.r == 16'd0));
`ifdef ALU_REMAINDER_EN
        check({tag, "_rem"},   32'(remainder), 32'(e.m));
`endif
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            opcode   = 3'd0;
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            rd       = 3'($urandom_range(0, 7));
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
            check({tag, "_hold_res"},   32'(result),    32'(e.r));
            check({tag, "_hold_carry"}, 32'(carry_out), 32'(e.c));
`ifdef ALU_REMAINDER_EN
            check({tag, "_hold_rem"},   32'(remainder), 32'(e.m));
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rise_ready"}, 32'(in_ready),  32'd1);
        dbg_sel = rdv;
        #1;
        check({tag, "_dbg"}, 32'(dbg_data), 32'(mregs[rdv]));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] av,
                          input logic [7:0] bv, input logic [2:0] rdv, input int hold);
        int lat, nbusy;
        send(op, av, bv, rdv);
        wait_out(lat, nbusy);
        consume(tag, rdv, lat, nbusy, hold);
    endtask

    // ---------------- driver task (16-bit) ----------------
    task automatic run_op_w(input string tag, input logic [2:0] op, input logic [15:0] av,
                            input logic [15:0] bv, input logic [3:0] rdv);
        res_t e;
        int guard, lat;
        e = model(16, op, av, bv);
        guard = 0;
        @(negedge clk);
        while (!w_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        w_opcode   = op;
        w_a        = av;
        w_b        = bv;
        w_rd       = rdv;
        w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!w_out_valid && lat < 100);
        check({tag, "_lat"},   32'(lat),      32'(e.lat));
        check({tag, "_res"},   32'(w_result), 32'(e.r));
        check({tag, "_carry"}, 32'(w_carry),  32'(e.c));
        check({tag, "_zero"},  32'(w_zero),   32'(e.r == 16'd0));
`ifdef ALU_REMAINDER_EN
        check({tag, "_rem"},   32'(w_rem),    32'(e.m));
`endif
        mregs_w[rdv] = e.r;
        w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_carry"},     32'(carry_out), 32'd0);
        check({tag, "_zero"},      32'(zero),      32'd0);
`ifdef ALU_REMAINDER_EN
        check({tag, "_rem"},       32'(remainder), 32'd0);
`endif
        check({tag, "_w_in_ready"}, 32'(w_in_ready), 32'd1);
        check({tag, "_w_result"},   32'(w_result),   32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check({tag, "_reg"}, 32'(dbg_data), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            w_dbg_sel = 4'(i);
            #1;
            check({tag, "_w_reg"}, 32'(w_dbg_data), 32'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0; rd = '0; dbg_sel = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_opcode = '0; w_a = '0; w_b = '0;
        w_rd = '0; w_dbg_sel = '0;
        foreach (mregs[i]) mregs[i] = '0;
        foreach (mregs_w[i]) mregs_w[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        run_op("add_200_100", 3'd0, 8'd200, 8'd100, 3'd2, 0);
        dbg_sel = 3'd2;
        #1;
        check("add_dbg_literal", 32'(dbg_data), 32'h2C);

        run_op("mul_20_15", 3'd5, 8'd20, 8'd15, 3'd1, 0);
        run_op("mul_12_10", 3'd5, 8'd12, 8'd10, 3'd3, 1);
        run_op("div_200_7", 3'd6, 8'd200, 8'd7, 3'd4, 0);
        run_op("div_5_0",   3'd6, 8'd5, 8'd0, 3'd6, 0);
        run_op("sub_5_9_bp", 3'd1, 8'd5, 8'd9, 3'd7, 5);
        run_op("and",       3'd2, 8'hF0, 8'h3C, 3'd0, 0);
        run_op("or",        3'd3, 8'hF0, 8'h0C, 3'd5, 0);
        run_op("div_255_1", 3'd6, 8'd255, 8'd1, 3'd0, 0);
        run_op("mul_255_255", 3'd5, 8'd255, 8'd255, 3'd5, 2);

        // Abort a multiply partway through.
        send(3'd5, 8'd20, 8'd15, 3'd5);
        repeat (4) @(negedge clk);
        check("midmul_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        foreach (mregs[i]) mregs[i] = '0;
        foreach (mregs_w[i]) mregs_w[i] = '0;
        check_reset_state("midmul_reset");
        @(negedge clk);
        rst = 1'b1;

        run_op("cmp_7_7",  3'd7, 8'd7, 8'd7, 3'd1, 0);
        run_op("cmp_3_9",  3'd7, 8'd3, 8'd9, 3'd2, 0);
        run_op("cmp_9_3",  3'd7, 8'd9, 8'd3, 3'd3, 0);
        run_op("xor_aa",   3'd4, 8'hAA, 8'hAA, 3'd4, 1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] av, bv;
            op = 3'($urandom_range(0, 7));
            av = 8'($urandom_range(0, 255));
            bv = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op("rand", op, av, bv, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check("final_reg", 32'(dbg_data), 32'(mregs[i]));
        end

        run_op_w("w_mul_300_300", 3'd5, 16'd300, 16'd300, 4'd0);
        w_dbg_sel = 4'd0;
        #1;
        check("w_mul_literal", 32'(w_dbg_data), 32'h5F90);
        for (int i = 0; i < 16; i++) begin
            run_op_w("w_fill", 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 4'(i));
        end
        for (int i = 0; i < 16; i++) begin
            w_dbg_sel = 4'(i);
            #1;
            check("w_readback", 32'(w_dbg_data), 32'(mregs_w[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
